// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared state encodings and parity helper for the configurable UART
package uart_pkg;

  localparam int DEFAULT_DIV = 651;
  localparam int MAX_DBITS   = 9;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } tx_state_t;

  // RX_BREAK holds off re-arming after a framing error until the line returns high
  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP,
    RX_BREAK
  } rx_state_t;

  // Zero-extended data does not change the reduction, so narrower frames pass through as-is
  function automatic logic parity_bit(input logic [MAX_DBITS-1:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_core_cfg_if.sv
// rtl/uart_core_cfg_if.sv - valid/ready byte streams between the UART engine and its FIFOs
interface uart_core_cfg_if #(
  parameter int DBITS = 8
);
  logic [DBITS-1:0] tx_data;
  logic             tx_valid;
  logic             tx_ready;
  logic [DBITS-1:0] rx_data;
  logic             rx_valid;
  logic             rx_ready;
  logic             rx_parity_err;
  logic             rx_frame_err;
  logic             rx_overrun;

  modport master (
    output tx_data, tx_valid, rx_ready,
    input  tx_ready, rx_data, rx_valid, rx_parity_err, rx_frame_err, rx_overrun
  );

  modport slave (
    input  tx_data, tx_valid, rx_ready,
    output tx_ready, rx_data, rx_valid, rx_parity_err, rx_frame_err, rx_overrun
  );
endinterface

// File: rtl/uart_baud_gen_cfg.sv
// rtl/uart_baud_gen_cfg.sv - free-running tick generator with a runtime divisor
module uart_baud_gen_cfg #(
  parameter int DIV_BITS = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [DIV_BITS-1:0] cfg_div,
  output logic                tick
);

  logic [DIV_BITS-1:0] cnt;
  logic [DIV_BITS-1:0] lim_m1;

  // The divisor is only sampled at the wrap so a change never truncates a period
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt    <= '0;
      lim_m1 <= '0;
    end else if (tick) begin
      cnt    <= '0;
      lim_m1 <= (cfg_div == '0) ? '0 : cfg_div - DIV_BITS'(1);
    end else begin
      cnt    <= cnt + DIV_BITS'(1);
    end
  end

  assign tick = (cnt == lim_m1);

endmodule

// File: rtl/uart_core_cfg.sv
// rtl/uart_core_cfg.sv - runtime-configurable UART engine: shared baud tick, TX and RX FSMs
module uart_core_cfg
  import uart_pkg::*;
#(
  parameter int DBITS      = 8,
  parameter int OVERSAMPLE = 16,
  parameter int DIV_BITS   = 16
) (
  input  logic                clk_100MHz,
  input  logic                reset,
  input  logic [DIV_BITS-1:0] cfg_div,
  input  logic                cfg_parity_en,
  input  logic                cfg_parity_odd,
  input  logic                cfg_two_stop,
  output logic                tx,
  input  logic                rx,
  output logic                tx_busy,
  uart_core_cfg_if.slave      bus
);

  localparam int             CW       = $clog2(OVERSAMPLE);
  localparam int             BW       = 4;
  localparam logic [CW-1:0]  OS_LAST  = CW'(OVERSAMPLE - 1);
  localparam logic [CW-1:0]  OS_HALF  = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [BW-1:0]  LAST_BIT = BW'(DBITS - 1);

  logic tick;

  uart_baud_gen_cfg #(.DIV_BITS(DIV_BITS)) u_baud (
    .clk     (clk_100MHz),
    .reset   (reset),
    .cfg_div (cfg_div),
    .tick    (tick)
  );

  tx_state_t        tx_state, tx_state_n;
  logic [CW-1:0]    tx_cnt, tx_cnt_n;
  logic [BW-1:0]    tx_idx, tx_idx_n;
  logic [DBITS-1:0] tx_shift, tx_shift_n;
  logic             tx_par, tx_par_n, tx_pen, tx_pen_n;
  logic             tx_two, tx_two_n, tx_stop2, tx_stop2_n;
  logic             tx_bit_end, tx_line, tx_rdy;

  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_idx   <= '0;
      tx_shift <= '0;
      tx_par   <= 1'b0;
      tx_pen   <= 1'b0;
      tx_two   <= 1'b0;
      tx_stop2 <= 1'b0;
    end else begin
      tx_state <= tx_state_n;
      tx_cnt   <= tx_cnt_n;
      tx_idx   <= tx_idx_n;
      tx_shift <= tx_shift_n;
      tx_par   <= tx_par_n;
      tx_pen   <= tx_pen_n;
      tx_two   <= tx_two_n;
      tx_stop2 <= tx_stop2_n;
    end
  end

  always_comb begin
    tx_state_n = tx_state;
    tx_cnt_n   = tx_cnt;
    tx_idx_n   = tx_idx;
    tx_shift_n = tx_shift;
    tx_par_n   = tx_par;
    tx_pen_n   = tx_pen;
    tx_two_n   = tx_two;
    tx_stop2_n = tx_stop2;
    tx_line    = 1'b1;
    tx_rdy     = 1'b0;
    tx_bit_end = tick && (tx_cnt == OS_LAST);
    if (tick) tx_cnt_n = tx_bit_end ? '0 : tx_cnt + CW'(1);
    case (tx_state)
      TX_IDLE: begin
        tx_rdy   = 1'b1;
        tx_cnt_n = '0;
        if (bus.tx_valid) begin
          tx_state_n = TX_START;
          tx_idx_n   = '0;
          tx_shift_n = bus.tx_data;
          tx_par_n   = parity_bit(MAX_DBITS'(bus.tx_data), cfg_parity_odd);
          tx_pen_n   = cfg_parity_en;
          tx_two_n   = cfg_two_stop;
          tx_stop2_n = 1'b0;
        end
      end
      TX_START: begin
        tx_line = 1'b0;
        if (tx_bit_end) tx_state_n = TX_DATA;
      end
      TX_DATA: begin
        tx_line = tx_shift[0];
        if (tx_bit_end) begin
          tx_shift_n = tx_shift >> 1;
          tx_idx_n   = tx_idx + BW'(1);
          if (tx_idx == LAST_BIT) tx_state_n = tx_pen ? TX_PARITY : TX_STOP;
        end
      end
      TX_PARITY: begin
        tx_line = tx_par;
        if (tx_bit_end) tx_state_n = TX_STOP;
      end
      TX_STOP: begin
        if (tx_bit_end) begin
          if (tx_two && !tx_stop2) tx_stop2_n = 1'b1;
          else                     tx_state_n = TX_IDLE;
        end
      end
      default: tx_state_n = TX_IDLE;
    endcase
  end

  assign tx           = reset | tx_line;
  assign tx_busy      = !tx_rdy;
  assign bus.tx_ready = tx_rdy;

  logic             rx_meta, rx_sync;
  rx_state_t        rx_state, rx_state_n;
  logic [CW-1:0]    rx_cnt, rx_cnt_n;
  logic [BW-1:0]    rx_idx, rx_idx_n;
  logic [DBITS-1:0] rx_shift, rx_shift_n;
  logic             rx_pen, rx_pen_n, rx_podd, rx_podd_n, rx_perr, rx_perr_n;
  logic             rx_bit_end, rx_half, stop_evt, stop_ferr;
  logic [DBITS-1:0] rx_data_q;
  logic             rx_valid_q, rx_perr_q, rx_ferr_q, rx_ovr_q;

  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      rx_meta  <= 1'b1;
      rx_sync  <= 1'b1;
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_idx   <= '0;
      rx_shift <= '0;
      rx_pen   <= 1'b0;
      rx_podd  <= 1'b0;
      rx_perr  <= 1'b0;
    end else begin
      rx_meta  <= rx;
      rx_sync  <= rx_meta;
      rx_state <= rx_state_n;
      rx_cnt   <= rx_cnt_n;
      rx_idx   <= rx_idx_n;
      rx_shift <= rx_shift_n;
      rx_pen   <= rx_pen_n;
      rx_podd  <= rx_podd_n;
      rx_perr  <= rx_perr_n;
    end
  end

  always_comb begin
    rx_state_n = rx_state;
    rx_cnt_n   = rx_cnt;
    rx_idx_n   = rx_idx;
    rx_shift_n = rx_shift;
    rx_pen_n   = rx_pen;
    rx_podd_n  = rx_podd;
    rx_perr_n  = rx_perr;
    stop_evt   = 1'b0;
    stop_ferr  = 1'b0;
    rx_bit_end = tick && (rx_cnt == OS_LAST);
    rx_half    = tick && (rx_cnt == OS_HALF);
    if (tick) rx_cnt_n = rx_cnt + CW'(1);
    case (rx_state)
      RX_IDLE: begin
        rx_cnt_n = '0;
        if (!rx_sync) begin
          rx_state_n = RX_START;
          rx_idx_n   = '0;
          rx_pen_n   = cfg_parity_en;
          rx_podd_n  = cfg_parity_odd;
          rx_perr_n  = 1'b0;
        end
      end
      RX_START: begin
        if (rx_half) begin
          rx_cnt_n   = '0;
          rx_state_n = rx_sync ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (rx_bit_end) begin
          rx_cnt_n   = '0;
          rx_shift_n = {rx_sync, rx_shift[DBITS-1:1]};
          rx_idx_n   = rx_idx + BW'(1);
          if (rx_idx == LAST_BIT) rx_state_n = rx_pen ? RX_PARITY : RX_STOP;
        end
      end
      RX_PARITY: begin
        if (rx_bit_end) begin
          rx_cnt_n   = '0;
          rx_perr_n  = rx_sync ^ parity_bit(MAX_DBITS'(rx_shift), rx_podd);
          rx_state_n = RX_STOP;
        end
      end
      RX_STOP: begin
        if (rx_bit_end) begin
          stop_evt   = 1'b1;
          stop_ferr  = !rx_sync;
          rx_state_n = rx_sync ? RX_IDLE : RX_BREAK;
        end
      end
      RX_BREAK: begin
        if (rx_sync) rx_state_n = RX_IDLE;
      end
      default: rx_state_n = RX_IDLE;
    endcase
  end

  // A consumer taking the held byte in the same cycle frees the slot for the new one
  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      rx_perr_q  <= 1'b0;
      rx_ferr_q  <= 1'b0;
      rx_ovr_q   <= 1'b0;
    end else begin
      rx_ovr_q <= 1'b0;
      if (stop_evt && (!rx_valid_q || bus.rx_ready)) begin
        rx_data_q  <= rx_shift;
        rx_perr_q  <= rx_perr;
        rx_ferr_q  <= stop_ferr;
        rx_valid_q <= 1'b1;
      end else begin
        if (stop_evt) rx_ovr_q <= 1'b1;
        if (rx_valid_q && bus.rx_ready) rx_valid_q <= 1'b0;
      end
    end
  end

  assign bus.rx_data       = rx_data_q;
  assign bus.rx_valid      = rx_valid_q;
  assign bus.rx_parity_err = rx_perr_q;
  assign bus.rx_frame_err  = rx_ferr_q;
  assign bus.rx_overrun    = rx_ovr_q;

endmodule

// File: tb/tb_uart_core_cfg.sv
// tb/tb_uart_core_cfg.sv - directed self-checking bench for uart_core_cfg
module tb_uart_core_cfg;
  import uart_pkg::*;

  localparam int DBITS    = 8;
  localparam int OS       = 16;
  localparam int DIV_BITS = 16;
  localparam int DIV      = 4;
  localparam int BITCYC   = OS * DIV;

  logic                clk_100MHz = 1'b0;
  logic                reset = 1'b1;
  logic [DIV_BITS-1:0] cfg_div = DIV_BITS'(DIV);
  logic                cfg_parity_en = 1'b0;
  logic                cfg_parity_odd = 1'b0;
  logic                cfg_two_stop = 1'b0;
  logic                tx;
  logic                rx;
  logic                tx_busy;
  logic                rx_drv = 1'b1;
  logic                loop_en = 1'b0;

  int total = 0;
  int bad   = 0;
  int rd    = 0;
  int rx_n  = 0;
  int ovr_cnt = 0;
  logic [9:0] rx_log [64];

  always #5 clk_100MHz = ~clk_100MHz;

  uart_core_cfg_if #(.DBITS(DBITS)) bus ();

  assign rx = loop_en ? tx : rx_drv;

  uart_core_cfg #(.DBITS(DBITS), .OVERSAMPLE(OS), .DIV_BITS(DIV_BITS)) dut (
    .clk_100MHz     (clk_100MHz),
    .reset          (reset),
    .cfg_div        (cfg_div),
    .cfg_parity_en  (cfg_parity_en),
    .cfg_parity_odd (cfg_parity_odd),
    .cfg_two_stop   (cfg_two_stop),
    .tx             (tx),
    .rx             (rx),
    .tx_busy        (tx_busy),
    .bus            (bus.slave)
  );

  always @(posedge clk_100MHz) begin
    if (!reset && bus.rx_valid && bus.rx_ready) begin
      rx_log[rx_n[5:0]] <= {bus.rx_parity_err, bus.rx_frame_err, bus.rx_data};
      rx_n <= rx_n + 1;
    end
    if (!reset && bus.rx_overrun) ovr_cnt <= ovr_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic get_rx(input string tag, input logic [9:0] exp);
    int n = 0;
    while (rx_n <= rd && n < 4000) begin
      @(negedge clk_100MHz);
      n++;
    end
    chk({tag, "_seen"}, 32'(rx_n > rd), 32'd1);
    if (rx_n > rd) begin
      chk(tag, 32'(rx_log[rd[5:0]]), 32'(exp));
      rd++;
    end
  endtask

  task automatic drive_bits(input logic [15:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      rx_drv = bits[i];
      repeat (BITCYC) @(negedge clk_100MHz);
    end
  endtask

  task automatic send(input logic [7:0] d, output int wait_cyc);
    int n = 0;
    bus.tx_data  = d;
    bus.tx_valid = 1'b1;
    while (bus.tx_ready !== 1'b1 && n < 2000) begin
      @(negedge clk_100MHz);
      n++;
    end
    @(negedge clk_100MHz);
    bus.tx_valid = 1'b0;
    wait_cyc = n;
  endtask

  initial begin
    logic       txs [640];
    logic [9:0] exp_bits;
    int         low;
    int         n;
    int         w;
    int         base;

    bus.tx_data  = '0;
    bus.tx_valid = 1'b0;
    bus.rx_ready = 1'b1;

    repeat (3) @(negedge clk_100MHz);
    chk("reset_outputs",
        {tx, bus.tx_ready, bus.rx_valid, bus.rx_parity_err, bus.rx_frame_err, bus.rx_overrun, tx_busy},
        7'b1100000);
    reset = 1'b0;
    repeat (5) @(negedge clk_100MHz);

    // 8N1 0xA5 launched in a tick cycle: every bit exactly 64 clocks
    n = 0;
    while (dut.tick !== 1'b1 && n < 100) begin
      @(negedge clk_100MHz);
      n++;
    end
    bus.tx_data  = 8'hA5;
    bus.tx_valid = 1'b1;
    @(negedge clk_100MHz);
    bus.tx_valid = 1'b0;
    low = 0;
    for (int k = 0; k < 640; k++) begin
      txs[k] = tx;
      if (bus.tx_ready === 1'b0) low++;
      @(negedge clk_100MHz);
    end
    exp_bits = 10'b1101001010;
    for (int j = 0; j < 10; j++)
      chk($sformatf("a5_bit%0d", j), {txs[64*j], txs[64*j+63]}, {exp_bits[j], exp_bits[j]});
    chk("a5_ready_low", low, 640);
    chk("a5_end_idle", {bus.tx_ready, tx, tx_busy}, 3'b110);

    // Loopback 8E2, back-to-back: each frame 12 bits, first start bit may be up to a tick short
    cfg_parity_en = 1'b1; cfg_parity_odd = 1'b0; cfg_two_stop = 1'b1;
    loop_en = 1'b1;
    repeat (2) @(negedge clk_100MHz);
    send(8'h00, w);
    send(8'hFF, w);
    chk("frame12_a", 32'(w >= 12*BITCYC - DIV + 1 && w <= 12*BITCYC), 32'd1);
    send(8'h3C, w);
    chk("frame12_b", 32'(w >= 12*BITCYC - DIV + 1 && w <= 12*BITCYC), 32'd1);
    get_rx("loop_00", 10'h000);
    get_rx("loop_ff", 10'h0FF);
    get_rx("loop_3c", 10'h03C);
    loop_en = 1'b0;

    // 8O1: 0x55 has even weight, so the odd-parity bit is 1
    cfg_parity_en = 1'b1; cfg_parity_odd = 1'b1; cfg_two_stop = 1'b0;
    repeat (3 * BITCYC) @(negedge clk_100MHz);
    drive_bits({5'b0, 1'b1, 1'b0, 8'h55, 1'b0}, 11);
    get_rx("bad_parity", 10'h255);
    drive_bits({5'b0, 1'b0, 1'b1, 8'h55, 1'b0}, 11);
    rx_drv = 1'b1;
    get_rx("stop_low", 10'h155);
    repeat (BITCYC) @(negedge clk_100MHz);

    // Break: one framing-error frame of zeros (odd parity expects 1 -> parity error too)
    drive_bits(16'h0000, 12);
    rx_drv = 1'b1;
    get_rx("break_frame", 10'h300);
    repeat (2 * BITCYC) @(negedge clk_100MHz);
    chk("break_single", rx_n - rd, 0);

    // Overrun: hold rx_ready low across two 8N1 frames
    cfg_parity_en = 1'b0;
    bus.rx_ready = 1'b0;
    base = ovr_cnt;
    repeat (BITCYC) @(negedge clk_100MHz);
    drive_bits({6'b0, 1'b1, 8'h12, 1'b0}, 10);
    chk("ovr_first_held", {bus.rx_valid, bus.rx_data}, 9'h112);
    drive_bits({6'b0, 1'b1, 8'h34, 1'b0}, 10);
    chk("ovr_pulse_once", ovr_cnt - base, 1);
    chk("ovr_data_kept", {bus.rx_valid, bus.rx_frame_err, bus.rx_data}, 10'h212);
    bus.rx_ready = 1'b1;
    @(negedge clk_100MHz);
    chk("ovr_valid_drop", bus.rx_valid, 1'b0);
    get_rx("ovr_byte", 10'h012);

    // Glitch of one tick on rx
    rx_drv = 1'b0;
    repeat (DIV) @(negedge clk_100MHz);
    rx_drv = 1'b1;
    repeat (3 * BITCYC) @(negedge clk_100MHz);
    chk("glitch_no_byte", rx_n - rd, 0);
    chk("glitch_no_valid", bus.rx_valid, 1'b0);
    chk("glitch_rx_idle", dut.rx_state, RX_IDLE);

    // Reset in the middle of DATA on both TX and RX
    send(8'hC3, w);
    drive_bits(16'b1010, 4);
    reset = 1'b1;
    #1;
    chk("rst_tx_high_now", tx, 1'b1);
    @(negedge clk_100MHz);
    chk("rst_next_cycle", {bus.tx_ready, bus.rx_valid, tx_busy, tx}, 4'b1001);
    chk("rst_rx_idle", dut.rx_state, RX_IDLE);
    rx_drv = 1'b1;
    @(negedge clk_100MHz);
    reset = 1'b0;
    repeat (BITCYC) @(negedge clk_100MHz);
    chk("rst_nothing_rx", rx_n - rd, 0);
    drive_bits({6'b0, 1'b1, 8'h96, 1'b0}, 10);
    get_rx("after_reset", 10'h096);

    // Divisor 0 behaves as 1 (tick every clock), then 2 (every other clock)
    cfg_div = '0;
    repeat (10) @(negedge clk_100MHz);
    n = 0;
    for (int k = 0; k < 16; k++) begin
      if (dut.tick === 1'b1) n++;
      @(negedge clk_100MHz);
    end
    chk("div0_ticks", n, 16);
    cfg_div = DIV_BITS'(2);
    repeat (10) @(negedge clk_100MHz);
    n = 0;
    for (int k = 0; k < 16; k++) begin
      if (dut.tick === 1'b1) n++;
      @(negedge clk_100MHz);
    end
    chk("div2_ticks", n, 8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
